// File: rtl/adc_buff_ctrl.sv
// ADC sample-buffer write controller: per-drdy bursts of CHANNELS words, block completion pulses.
// Optional overrun detection is built when ADC_BUFF_OVERRUN_EN is defined.
module adc_buff_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int CHANNELS = 2,
    parameter int BLOCK_W  = 8,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BI_W    = ADDR_W - BLOCK_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_pulse,
    input  logic              drdy,
    input  logic              stop_flag,
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [CH_W-1:0]   ch_sel,
    output logic              block_done,
    output logic [BI_W-1:0]   block_idx,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              drdy_q;
    logic              pend_q, pend_d;
    logic [BI_W-1:0]   idx_q, idx_d;
    logic              drdy_rise;
    logic              ch_last;
    logic              ovr_hit;

    assign drdy_rise = drdy & ~drdy_q;
    assign ch_last   = (ch_q == CH_W'(CHANNELS - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ch_d    = ch_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        ovr_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (start_pulse) begin
                    addr_d  = '0;
                    ch_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (drdy_rise || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ovr_hit = drdy_rise;
                addr_d  = addr_q + ADDR_W'(1);
                ch_d    = ch_last ? '0 : ch_q + CH_W'(1);
                if (ch_last) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                ovr_hit = drdy_rise;
                if (addr_q[BLOCK_W-1:0] == '0) begin
                    // index latched here so it is valid alongside block_done
                    idx_d   = addr_q[ADDR_W-1:BLOCK_W] - BI_W'(1);
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                pend_d  = drdy_rise & ~stop_flag;
                state_d = stop_flag ? S_IDLE : S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ch_q    <= '0;
            drdy_q  <= 1'b0;
            pend_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ch_q    <= ch_d;
            drdy_q  <= drdy;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
        end
    end

`ifdef ADC_BUFF_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (state_q == S_IDLE && start_pulse) begin
            ovr_d = 1'b0;
        end else if (ovr_hit) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun = ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = ovr_hit;
    assign overrun    = 1'b0;
`endif

    assign we         = (state_q == S_WRITE);
    assign write_addr = addr_q;
    assign ch_sel     = ch_q;
    assign block_done = (state_q == S_DONE);
    assign block_idx  = idx_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_buff_ctrl.sv
// Directed bench for adc_buff_ctrl: default geometry instance plus a CHANNELS=4, BLOCK_W=3 instance.
module tb_adc_buff_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

`ifdef ADC_BUFF_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    // default instance
    logic       r0 = 1'b1, st0 = 1'b0, dr0 = 1'b0, sf0 = 1'b0;
    logic       we0, bd0, busy0, ovr0;
    logic [8:0] wa0;
    logic [0:0] ch0;
    logic [0:0] bi0;

    adc_buff_ctrl dut0 (
        .clk(clk), .reset(r0), .start_pulse(st0), .drdy(dr0), .stop_flag(sf0),
        .we(we0), .write_addr(wa0), .ch_sel(ch0), .block_done(bd0),
        .block_idx(bi0), .busy(busy0), .overrun(ovr0)
    );

    // CHANNELS=4, BLOCK_W=3, ADDR_W=5 instance
    logic       r1 = 1'b1, st1 = 1'b0, dr1 = 1'b0, sf1 = 1'b0;
    logic       we1, bd1, busy1, ovr1;
    logic [4:0] wa1;
    logic [1:0] ch1;
    logic [1:0] bi1;

    adc_buff_ctrl #(.ADDR_W(5), .CHANNELS(4), .BLOCK_W(3)) dut1 (
        .clk(clk), .reset(r1), .start_pulse(st1), .drdy(dr1), .stop_flag(sf1),
        .we(we1), .write_addr(wa1), .ch_sel(ch1), .block_done(bd1),
        .block_idx(bi1), .busy(busy1), .overrun(ovr1)
    );

    int qa0[$], qc0[$], qt0[$], qi0[$], qd0[$];
    int qa1[$], qc1[$], qi1[$];

    always @(negedge clk) begin
        if (we0) begin
            qa0.push_back(int'(wa0));
            qc0.push_back(int'(ch0));
            qt0.push_back(cyc);
        end
        if (bd0) begin
            qi0.push_back(int'(bi0));
            qd0.push_back(cyc);
        end
        if (we1) begin
            qa1.push_back(int'(wa1));
            qc1.push_back(int'(ch1));
        end
        if (bd1) qi1.push_back(int'(bi1));
    end

    task automatic clr0();
        qa0.delete(); qc0.delete(); qt0.delete(); qi0.delete(); qd0.delete();
    endtask

    task automatic rst0();
        @(negedge clk) r0 = 1'b1;
        @(negedge clk) r0 = 1'b0;
        clr0();
    endtask

    task automatic start0();
        @(negedge clk) st0 = 1'b1;
        @(negedge clk) st0 = 1'b0;
    endtask

    // rise drdy; the next rise comes 'spacing' cycles later
    task automatic edge0(input int spacing);
        @(negedge clk) dr0 = 1'b1;
        @(negedge clk) dr0 = 1'b0;
        repeat (spacing - 2) @(negedge clk);
    endtask

    task automatic edge1(input int spacing);
        @(negedge clk) dr1 = 1'b1;
        @(negedge clk) dr1 = 1'b0;
        repeat (spacing - 2) @(negedge clk);
    endtask

    int errs;

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_we", 32'(we0), 0);
        check("rst_addr", 32'(wa0), 0);
        check("rst_ch", 32'(ch0), 0);
        check("rst_bd", 32'(bd0), 0);
        check("rst_idx", 32'(bi0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_ovr", 32'(ovr0), 0);
        rst0();

        // single event
        start0();
        check("busy_after_start", 32'(busy0), 1);
        edge0(10);
        check("t1_nwr", 32'(qa0.size()), 2);
        check("t1_a0", 32'(qa0[0]), 0);
        check("t1_c0", 32'(qc0[0]), 0);
        check("t1_a1", 32'(qa0[1]), 1);
        check("t1_c1", 32'(qc0[1]), 1);
        check("t1_nbd", 32'(qi0.size()), 0);
        check("t1_busy", 32'(busy0), 1);

        // full block; 128th edge followed 4 cycles later by an edge landing in DONE
        for (int i = 1; i < 128; i++) edge0(i == 127 ? 4 : 10);
        edge0(10);
        check("t2_nwr", 32'(qa0.size()), 258);
        errs = 0;
        for (int k = 0; k < 258; k++) begin
            if (qa0[k] != k || qc0[k] != k % 2) errs++;
        end
        check("t2_seq_errs", 32'(errs), 0);
        check("t2_nbd", 32'(qi0.size()), 1);
        check("t2_idx", 32'(qi0[0]), 0);
        check("t2_bd_lat", 32'(qd0[0] - qt0[255]), 2);

        // second block and wrap
        for (int i = 129; i < 256; i++) edge0(10);
        check("t3_nwr", 32'(qa0.size()), 512);
        check("t3_nbd", 32'(qi0.size()), 2);
        check("t3_idx1", 32'(qi0[1]), 1);
        check("t3_wrap_addr", 32'(wa0), 0);
        edge0(10);
        check("t3_257_addr", 32'(qa0[512]), 0);
        check("t3_257_ch", 32'(qc0[512]), 0);

        // stop after first block
        rst0();
        start0();
        sf0 = 1'b1;
        for (int i = 0; i < 128; i++) edge0(10);
        check("t4_nbd", 32'(qi0.size()), 1);
        check("t4_busy", 32'(busy0), 0);
        edge0(10);
        edge0(10);
        check("t4_idle_nwr", 32'(qa0.size()), 256);
        sf0 = 1'b0;
        start0();
        edge0(10);
        check("t4_restart_nwr", 32'(qa0.size()), 258);
        check("t4_restart_addr", 32'(qa0[256]), 0);

        // overrun
        rst0();
        start0();
        sf0 = 1'b1;
        edge0(2);
        edge0(10);
        check("t5_nwr", 32'(qa0.size()), 2);
        check("t5_ovr", 32'(ovr0), 32'(OVR_EXP));
        for (int i = 0; i < 127; i++) edge0(10);
        check("t5_nwr_blk", 32'(qa0.size()), 256);
        check("t5_ovr_held", 32'(ovr0), 32'(OVR_EXP));
        check("t5_busy", 32'(busy0), 0);
        sf0 = 1'b0;
        start0();
        check("t5_ovr_clr", 32'(ovr0), 0);

        // 4-channel instance: reset during third write cycle
        @(negedge clk) r1 = 1'b0;
        @(negedge clk) st1 = 1'b1;
        @(negedge clk) st1 = 1'b0;
        @(negedge clk) dr1 = 1'b1;
        @(negedge clk) dr1 = 1'b0;
        @(negedge clk);
        @(negedge clk) r1 = 1'b1;
        @(negedge clk);
        check("t6_rst_we", 32'(we1), 0);
        check("t6_rst_addr", 32'(wa1), 0);
        check("t6_rst_ch", 32'(ch1), 0);
        check("t6_rst_busy", 32'(busy1), 0);
        check("t6_rst_bd", 32'(bd1), 0);
        check("t6_rst_idx", 32'(bi1), 0);
        check("t6_pre_nwr", 32'(qa1.size()), 3);
        qa1.delete(); qc1.delete(); qi1.delete();
        @(negedge clk) r1 = 1'b0;
        @(negedge clk) st1 = 1'b1;
        @(negedge clk) st1 = 1'b0;
        edge1(8);
        edge1(8);
        check("t6_nwr", 32'(qa1.size()), 8);
        errs = 0;
        for (int k = 0; k < 8; k++) begin
            if (qa1[k] != k || qc1[k] != k % 4) errs++;
        end
        check("t6_seq_errs", 32'(errs), 0);
        check("t6_nbd", 32'(qi1.size()), 1);
        check("t6_idx", 32'(qi1[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
